// File: rtl/mux21_arbiter.sv
// mux21_arbiter: merges the class-0 and class-1 FIFOs into one registered
// DATA_W stream. The arbiter is round-robin with a burst limit of BURST_LEN
// pops per turn. The input side uses a combinational pop handshake, and the
// output side is a registered push that stalls on pause.
// Optional build macro: MUX21_FIXED_PRIO_EN selects fixed priority to class 0.
// In that build, last_grant and the burst limit are not used.
module mux21_arbiter #(
  parameter int DATA_W    = 10,
  parameter int BURST_LEN = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fifo_empty_0,
  input  logic              fifo_empty_1,
  input  logic [DATA_W-1:0] in0,
  input  logic [DATA_W-1:0] in1,
  input  logic              pause,
  output logic              pop_0,
  output logic              pop_1,
  output logic [DATA_W-1:0] out,
  output logic              push
);
  localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_LEN - 1);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] burst_cnt, cnt_nxt;
  logic             last_grant, lg_nxt;
  logic             ne0, ne1;

  assign ne0 = !fifo_empty_0;
  assign ne1 = !fifo_empty_1;

  // A pop only happens from the granted, non-empty FIFO when downstream has room.
  assign pop_0 = (state == GRANT0) & ne0 & !pause & !reset;
  assign pop_1 = (state == GRANT1) & ne1 & !pause & !reset;

`ifdef MUX21_FIXED_PRIO_EN
  // Fixed priority: class 0 preempts class 1 at the next word boundary.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = burst_cnt;
    lg_nxt    = last_grant;
    if (!pause) begin
      unique case (state)
        IDLE:    if (ne0)      state_nxt = GRANT0;
                 else if (ne1) state_nxt = GRANT1;
        GRANT0:  if (!ne0)     state_nxt = ne1 ? GRANT1 : IDLE;
        GRANT1:  if (ne0)      state_nxt = GRANT0;
                 else if (!ne1) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end
`else
  // Round-robin: switch on burst expiry or when the served FIFO runs dry.
  // pause freezes state and burst_cnt.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = burst_cnt;
    lg_nxt    = last_grant;
    if (!pause) begin
      unique case (state)
        IDLE: if (ne0 || ne1) begin
          cnt_nxt = '0;
          if (last_grant) state_nxt = ne0 ? GRANT0 : GRANT1;
          else            state_nxt = ne1 ? GRANT1 : GRANT0;
        end
        GRANT0: if (ne0) begin
          if (burst_cnt == CNT_MAX) begin
            cnt_nxt = '0;
            if (ne1) begin
              state_nxt = GRANT1;
              lg_nxt    = 1'b0;
            end
          end else begin
            cnt_nxt = burst_cnt + CNT_W'(1);
          end
        end else begin
          cnt_nxt = '0;
          if (ne1) begin
            state_nxt = GRANT1;
            lg_nxt    = 1'b0;
          end else begin
            state_nxt = IDLE;
          end
        end
        GRANT1: if (ne1) begin
          if (burst_cnt == CNT_MAX) begin
            cnt_nxt = '0;
            if (ne0) begin
              state_nxt = GRANT0;
              lg_nxt    = 1'b1;
            end
          end else begin
            cnt_nxt = burst_cnt + CNT_W'(1);
          end
        end else begin
          cnt_nxt = '0;
          if (ne0) begin
            state_nxt = GRANT0;
            lg_nxt    = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end
`endif

  // State register plus the one-stage output register.
  // The popped word is pushed on the next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      burst_cnt  <= '0;
      last_grant <= 1'b1;
      push       <= 1'b0;
      out        <= '0;
    end else begin
      state      <= state_nxt;
      burst_cnt  <= cnt_nxt;
      last_grant <= lg_nxt;
      push       <= pop_0 | pop_1;
      if (pop_0)      out <= in0;
      else if (pop_1) out <= in1;
    end
  end
endmodule

// File: tb/tb_mux21_arbiter.sv
// Bench for mux21_arbiter in the default round-robin build, with BURST_LEN=4.
// FIFO models feed the DUT. The scoreboard queue holds the word order the
// arbiter must produce, and it is loaded when the FIFOs are filled.
module tb_mux21_arbiter;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       fifo_empty_0 = 1'b1, fifo_empty_1 = 1'b1;
  logic [9:0] in0 = '0, in1 = '0;
  logic       pause = 1'b0;
  logic       pop_0, pop_1, push;
  logic [9:0] out;

  mux21_arbiter #(.DATA_W(10), .BURST_LEN(4)) dut (
    .clk(clk), .reset(reset), .fifo_empty_0(fifo_empty_0), .fifo_empty_1(fifo_empty_1),
    .in0(in0), .in1(in1), .pause(pause), .pop_0(pop_0), .pop_1(pop_1), .out(out), .push(push)
  );

  always #5 clk = ~clk;

  logic [9:0]  q0[$], q1[$], sb[$];
  logic        popped_last = 1'b0;
  logic [31:0] pop_hist = '0;
  int          n_pop0 = 0, n_pop1 = 0;
  int          total = 0, bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // One cycle. At the negedge, registered outputs are checked first.
  // The FIFO heads are driven next, and then the combinational pops are sampled.
  task automatic step(input logic p);
    @(negedge clk);
    chk("push_lat", push, popped_last);
    if (push) begin
      if (sb.size() == 0) chk("sb_underflow", 1, 0);
      else                chk("out", out, sb.pop_front());
    end
    pause        = p;
    fifo_empty_0 = (q0.size() == 0);
    fifo_empty_1 = (q1.size() == 0);
    in0          = fifo_empty_0 ? 10'h0 : q0[0];
    in1          = fifo_empty_1 ? 10'h0 : q1[0];
    #1;
    chk("pop_both", pop_0 & pop_1, 0);
    chk("pop_on_empty", (pop_0 & fifo_empty_0) | (pop_1 & fifo_empty_1), 0);
    chk("pop_on_pause_rst", (pop_0 | pop_1) & (pause | reset), 0);
    if (pop_0) begin void'(q0.pop_front()); n_pop0++; end
    if (pop_1) begin void'(q1.pop_front()); n_pop1++; end
    popped_last = pop_0 | pop_1;
    pop_hist    = {pop_hist[30:0], popped_last};
  endtask

  task automatic do_reset();
    q0.delete(); q1.delete(); sb.delete();
    reset = 1'b1;
    step(0); step(0);
    reset = 1'b0;
    n_pop0 = 0; n_pop1 = 0; pop_hist = '0;
  endtask

  task automatic drain(input int maxc);
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || popped_last || sb.size() != 0) && n < maxc) begin
      step(0);
      n++;
    end
    chk("drain_timeout", n >= maxc, 0);
    chk("sb_left", sb.size(), 0);
  endtask

  initial begin
    // T1: reset with both FIFOs non-empty. No pops, and push and out stay 0.
    q0.push_back(10'h3FF); q1.push_back(10'h2AA);
    step(0); step(0);
    chk("rst_push", push, 0);
    chk("rst_out", out, 0);
    do_reset();

    // T2: single channel. There is one IDLE bubble, then six back-to-back ch0 pops.
    for (int i = 1; i <= 6; i++) begin q0.push_back(10'(i)); sb.push_back(10'(i)); end
    repeat (8) step(0);
    chk("t2_pop_pattern", pop_hist[7:0], 8'b0111_1110);
    chk("t2_no_pop1", n_pop1, 0);
    drain(20);

    // T3: both channels loaded. Bursts of 4 alternate, starting with ch0.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      q0.push_back(10'h0A0 + 10'(i));
      q1.push_back(10'h1B0 + 10'(i));
    end
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 4; i++) sb.push_back(10'h0A0 + 10'(4*b + i));
      for (int i = 0; i < 4; i++) sb.push_back(10'h1B0 + 10'(4*b + i));
    end
    drain(80);

    // T4: pause after the 2nd ch0 pop. Exactly 2 more ch0 pops follow, then ch1.
    do_reset();
    for (int i = 0; i < 6; i++) q0.push_back(10'h040 + 10'(i));
    for (int i = 0; i < 4; i++) q1.push_back(10'h280 + 10'(i));
    for (int i = 0; i < 4; i++) sb.push_back(10'h040 + 10'(i));
    for (int i = 0; i < 4; i++) sb.push_back(10'h280 + 10'(i));
    for (int i = 4; i < 6; i++) sb.push_back(10'h040 + 10'(i));
    begin
      int n = 0;
      while (n_pop0 < 2 && n < 20) begin step(0); n++; end
      chk("t4_reach_timeout", n >= 20, 0);
    end
    step(1);
    chk("t4_inflight_push", push, 1);
    step(1);
    chk("t4_push_stops", push, 0);
    step(1);
    chk("t4_pause_pops", n_pop0, 2);
    drain(40);

    // T5: ch0 runs dry early. There is one pop-free switch cycle, ch1 drains, then IDLE.
    do_reset();
    q0.push_back(10'h011); q0.push_back(10'h012);
    q1.push_back(10'h155); q1.push_back(10'h156);
    sb.push_back(10'h011); sb.push_back(10'h012);
    sb.push_back(10'h155); sb.push_back(10'h156);
    repeat (8) step(0);
    chk("t5_pop_pattern", pop_hist[7:0], 8'b0110_1100);
    chk("t5_counts", {n_pop0[15:0], n_pop1[15:0]}, {16'd2, 16'd2});
    drain(20);

    // After idling, a new ch1-only word is served after one bubble.
    q1.push_back(10'h3C3); sb.push_back(10'h3C3);
    pop_hist = '0;
    repeat (3) step(0);
    chk("idle_restart", pop_hist[2:0], 3'b010);
    drain(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
